// File: rtl/vanishing_move_board.sv
// rtl/vanishing_move_board.sv - board state and per-player move history for disappearing-mark tic-tac-toe
// Accepts one move per handshake, answers in the following RESP cycle, and owns the packed board.
module vanishing_move_board #(
    parameter int CELLS       = 9,
    parameter int IDX_W       = 4,
    parameter int HIST_DEPTH  = 3,
    parameter int VANISH_MODE = 0,
    parameter int FIRST_X     = 1,
    localparam int CW         = $clog2(HIST_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 mv_valid,
    input  logic                 mv_player,
    input  logic [IDX_W-1:0]     mv_pos,
    output logic                 mv_ready,
    output logic                 mv_ack,
    output logic                 mv_err,
    output logic                 rm_valid,
    output logic [IDX_W-1:0]     rm_pos,
    output logic [2*CELLS-1:0]   board,
    output logic                 turn,
    output logic [CW-1:0]        x_count,
    output logic [CW-1:0]        o_count,
    output logic [IDX_W-1:0]     x_oldest,
    output logic [IDX_W-1:0]     o_oldest
);

    localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(HIST_DEPTH);
    localparam logic TURN_RST = (FIRST_X != 0);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t             r_state, w_next;
    logic [2*CELLS-1:0] r_board;
    logic               r_turn;
    logic [CW-1:0]      r_cnt  [2];
    logic [PW-1:0]      r_head [2];
    logic [PW-1:0]      r_tail [2];
    logic [IDX_W-1:0]   r_q    [2][HIST_DEPTH];
    logic               r_ack, r_err, r_rm_valid;
    logic [IDX_W-1:0]   r_rm_pos;

    logic               w_accept, w_occ, w_pos_bad, w_mfull, w_ofull;
    logic               w_vanish, w_vplayer, w_reject;
    logic [IDX_W-1:0]   w_vpos;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (32'(p) == HIST_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        mv_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                mv_ready = 1'b1;
                if (mv_valid) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (clear) w_next = S_IDLE;
    end

    always_comb begin
        w_occ = 1'b0;
        for (int i = 0; i < CELLS; i++)
            if (32'(mv_pos) == i) w_occ = |r_board[2*i +: 2];
    end

    assign w_accept  = (r_state == S_IDLE) && mv_valid && !clear;
    assign w_pos_bad = (32'(mv_pos) >= CELLS);
    assign w_mfull   = (r_cnt[mv_player] == FULL);
    assign w_ofull   = (r_cnt[~mv_player] == FULL);
    assign w_vanish  = (VANISH_MODE == 0) ? w_mfull : (w_mfull && w_ofull);
    assign w_vplayer = (VANISH_MODE == 0) ? mv_player : ~mv_player;
    assign w_vpos    = r_q[w_vplayer][r_head[w_vplayer]];
    assign w_reject  = w_pos_bad || (mv_player != r_turn) || w_occ ||
                       ((VANISH_MODE != 0) && w_mfull && !w_ofull);

    // FIFO contents need no reset: the head entry is only exposed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (w_accept && !w_reject)
            r_q[mv_player][r_tail[mv_player]] <= mv_pos;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_board    <= '0;
            r_turn     <= TURN_RST;
            r_cnt      <= '{default: '0};
            r_head     <= '{default: '0};
            r_tail     <= '{default: '0};
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rm_valid <= 1'b0;
            r_rm_pos   <= '0;
        end else if (clear) begin
            r_board    <= '0;
            r_turn     <= TURN_RST;
            r_cnt      <= '{default: '0};
            r_head     <= '{default: '0};
            r_tail     <= '{default: '0};
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rm_valid <= 1'b0;
            r_rm_pos   <= '0;
        end else begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rm_valid <= 1'b0;
            if (w_accept && w_reject) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_ack      <= 1'b1;
                r_rm_valid <= w_vanish;
                if (w_vanish) r_rm_pos <= w_vpos;
                for (int i = 0; i < CELLS; i++) begin
                    if (w_vanish && 32'(w_vpos) == i) r_board[2*i +: 2] <= 2'b00;
                    if (32'(mv_pos) == i)             r_board[2*i +: 2] <= {mv_player, ~mv_player};
                end
                r_tail[mv_player] <= f_next(r_tail[mv_player]);
                // Pushing onto a full FIFO retires its head; in mode 1 that mark stays on the board.
                if (w_mfull) r_head[mv_player] <= f_next(r_head[mv_player]);
                else         r_cnt[mv_player]  <= r_cnt[mv_player] + 1'b1;
                if (VANISH_MODE != 0 && w_vanish) begin
                    r_head[~mv_player] <= f_next(r_head[~mv_player]);
                    r_cnt[~mv_player]  <= r_cnt[~mv_player] - 1'b1;
                end
                r_turn <= ~r_turn;
            end
        end
    end

    assign mv_ack   = r_ack && !clear;
    assign mv_err   = r_err && !clear;
    assign rm_valid = r_rm_valid && !clear;
    assign rm_pos   = r_rm_pos;
    assign board    = r_board;
    assign turn     = r_turn;
    assign x_count  = r_cnt[1];
    assign o_count  = r_cnt[0];
    assign x_oldest = (r_cnt[1] == '0) ? '0 : r_q[1][r_head[1]];
    assign o_oldest = (r_cnt[0] == '0) ? '0 : r_q[0][r_head[0]];

endmodule
